signed_divider_adapter: RTL and testbench
=========================================

Name: signed_divider_adapter

Overview:
- Front/back-end stage wrapped around the unsigned iterative divider core. It sits directly upstream and downstream of the core.
- Upstream: accepts signed or unsigned operands over a valid/ready handshake, converts them to magnitudes, and resolves special cases without using the core.
- Downstream: consumes the core's quotient and remainder, applies sign correction, and presents the final result over a valid/ready handshake.
- Also covers the dividend < divisor case, which the core does not handle.

Parameters:
DATA_WIDTH, 16, operand/result width; power of 2, ≥ 4; must match the core.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
clk_en_i  in  1  clock enable; when low, all registers hold
op_valid_i  in  1  operand request
op_ready_o  out  1  adapter can accept operands (high only in IDLE)
dividend_i  in  DATA_WIDTH  dividend
divisor_i  in  DATA_WIDTH  divisor
signed_i  in  1  1 = operands are two's complement
core_dividend_o  out  DATA_WIDTH  dividend magnitude to core
core_divisor_o  out  DATA_WIDTH  divisor magnitude to core
core_valid_o  out  1  one-cycle start pulse to core
core_idle_i  in  1  core idle
core_quotient_i  in  DATA_WIDTH  core quotient
core_remainder_i  in  DATA_WIDTH  core remainder
core_valid_i  in  1  core result valid (one-cycle pulse)
result_valid_o  out  1  result available
result_ready_i  in  1  consumer accepts result
quotient_o  out  DATA_WIDTH  final quotient
remainder_o  out  DATA_WIDTH  final remainder
divide_by_zero_o  out  1  result came from a zero divisor
overflow_o  out  1  result came from signed MIN / -1

Behaviour:
- All outputs are registered. Reset values:
  - state IDLE, so op_ready_o=1
  - core_valid_o=0, result_valid_o=0
  - quotient_o=0, remainder_o=0, divide_by_zero_o=0, overflow_o=0
  - core_dividend_o=0, core_divisor_o=0
- A reset mid-operation returns to IDLE and drops the operation. The core shares rst_n_i.
- All state updates are qualified by clk_en_i.
- States: IDLE, ISSUE, WAIT, FIXUP, RESULT.
- IDLE:
  - Accept when op_valid_i && op_ready_o. Register the sign flags and magnitudes.
  - sign_q = signed_i & (a[MSB]^b[MSB]).
  - sign_r = signed_i & a[MSB].
  - Magnitudes: |x| is the two's-complement negation when signed_i && x[MSB], otherwise x. |MIN| = 2^(N-1), taken as unsigned.
  - Classification is evaluated at accept, in priority order:
    1. divisor==0: quotient=all ones, remainder=dividend_i, divide_by_zero=1 → RESULT.
    2. signed_i && dividend==MIN && divisor==all ones: quotient=MIN, remainder=0, overflow=1 → RESULT.
    3. |a| < |b| (unsigned compare): quotient=0, remainder=dividend_i unchanged → RESULT.
    4. Otherwise → ISSUE, with core_dividend_o=|a| and core_divisor_o=|b|.
- ISSUE:
  - If core_idle_i=1: assert core_valid_o for exactly one cycle, then go to WAIT.
  - Otherwise hold in ISSUE with core_valid_o=0.
  - core_dividend_o and core_divisor_o stay stable through ISSUE and WAIT.
- WAIT:
  - On core_valid_i, capture the core quotient and remainder, then go to FIXUP.
  - core_valid_i in any other state is ignored.
- FIXUP:
  - quotient = sign_q ? -q : q.
  - remainder = sign_r ? -r : r.
  - Then go to RESULT.
- RESULT:
  - result_valid_o=1. All result outputs and flags are held stable until result_ready_i.
  - On handshake: next cycle result_valid_o=0, state IDLE. Flags clear on the next accept.
- Sign convention: quotient truncates toward zero; the remainder takes the sign of the dividend.
- Latency:
  - Special case: result_valid_o asserts 1 cycle after accept.
  - Normal path: accept → ISSUE (1 cycle) → core latency L → FIXUP (1 cycle) → result_valid_o.
- Exactly one core_valid_o pulse per normal operation; none for special cases.
- op_ready_o=0 in every state except IDLE. A new operation is accepted no earlier than the cycle after the result handshake.

Test Plan:
1. Unsigned 100/7 → core sees 100 and 7 with one core_valid_o pulse → quotient 14, remainder 2, flags 0.
2. Signed cases → core sees 100/7 in each case:
   - -100/7 → quotient 0xFFF2, remainder 0xFFFE.
   - 100/-7 → quotient 0xFFF2, remainder 0x0002.
   - -100/-7 → quotient 0x000E, remainder 0xFFFE.
3. 1234/0 (either signedness) → quotient 0xFFFF, remainder 0x04D2, divide_by_zero_o=1, no core_valid_o, result_valid_o one cycle after accept.
4. Overflow and small-dividend cases:
   - Signed 0x8000/0xFFFF → quotient 0x8000, remainder 0, overflow_o=1, core unused.
   - Unsigned 0x8000/0xFFFF → quotient 0, remainder 0x8000, flags 0, core unused.
5. Busy core and backpressure:
   - Hold core_idle_i=0 for 3 cycles → core_valid_o is delayed until idle.
   - Hold result_ready_i low for 5 cycles → outputs stable, op_ready_o=0.
   - Deassert clk_en_i for 2 cycles in WAIT → state and outputs frozen.
6. Assert rst_n_i low asynchronously mid-WAIT → immediately state IDLE, op_ready_o=1, result_valid_o=0, core_valid_o=0. A later stale core_valid_i is ignored.

Source files
------------

// File: rtl/signed_divider_adapter_if.sv
// Handshake and data bundle between the signed divider adapter, its operand
// producer, result consumer and the unsigned divider core.
interface signed_divider_adapter_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  op_valid_i;
    logic                  op_ready_o;
    logic [DATA_WIDTH-1:0] dividend_i;
    logic [DATA_WIDTH-1:0] divisor_i;
    logic                  signed_i;
    logic [DATA_WIDTH-1:0] core_dividend_o;
    logic [DATA_WIDTH-1:0] core_divisor_o;
    logic                  core_valid_o;
    logic                  core_idle_i;
    logic [DATA_WIDTH-1:0] core_quotient_i;
    logic [DATA_WIDTH-1:0] core_remainder_i;
    logic                  core_valid_i;
    logic                  result_valid_o;
    logic                  result_ready_i;
    logic [DATA_WIDTH-1:0] quotient_o;
    logic [DATA_WIDTH-1:0] remainder_o;
    logic                  divide_by_zero_o;
    logic                  overflow_o;

    modport slave (
        input  op_valid_i, dividend_i, divisor_i, signed_i,
        input  core_idle_i, core_quotient_i, core_remainder_i, core_valid_i,
        input  result_ready_i,
        output op_ready_o, core_dividend_o, core_divisor_o, core_valid_o,
        output result_valid_o, quotient_o, remainder_o, divide_by_zero_o, overflow_o
    );

    modport master (
        output op_valid_i, dividend_i, divisor_i, signed_i,
        output core_idle_i, core_quotient_i, core_remainder_i, core_valid_i,
        output result_ready_i,
        input  op_ready_o, core_dividend_o, core_divisor_o, core_valid_o,
        input  result_valid_o, quotient_o, remainder_o, divide_by_zero_o, overflow_o
    );
endinterface

// File: rtl/signed_divider_adapter.sv
// Signed front/back end around the unsigned iterative divider core: magnitude
// conversion and special-case resolution on entry, sign correction on exit.
module signed_divider_adapter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clk_en_i,
    signed_divider_adapter_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIXUP, RESULT} state_t;

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    // |MIN| wraps back to MIN, which is exactly 2^(N-1) read as unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] x,
                                                        input logic                         is_signed);
        return (is_signed && x[DATA_WIDTH-1]) ? negate(x) : x;
    endfunction

    state_t                state_q, state_d;
    logic                  quot_neg_q, quot_neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic [DATA_WIDTH-1:0] core_dividend_q, core_dividend_d;
    logic [DATA_WIDTH-1:0] core_divisor_q, core_divisor_d;
    logic                  core_valid_q, core_valid_d;
    logic [DATA_WIDTH-1:0] core_quot_q, core_quot_d;
    logic [DATA_WIDTH-1:0] core_rem_q, core_rem_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;
    logic                  result_valid_q, result_valid_d;

    logic signed [DATA_WIDTH-1:0] op_a, op_b;
    logic        [DATA_WIDTH-1:0] mag_a, mag_b;

    assign op_a  = bus.dividend_i;
    assign op_b  = bus.divisor_i;
    assign mag_a = magnitude(op_a, bus.signed_i);
    assign mag_b = magnitude(op_b, bus.signed_i);

    always_comb begin
        state_d         = state_q;
        quot_neg_d      = quot_neg_q;
        rem_neg_d       = rem_neg_q;
        core_dividend_d = core_dividend_q;
        core_divisor_d  = core_divisor_q;
        core_valid_d    = 1'b0;
        core_quot_d     = core_quot_q;
        core_rem_d      = core_rem_q;
        quotient_d      = quotient_q;
        remainder_d     = remainder_q;
        dbz_d           = dbz_q;
        ovf_d           = ovf_q;
        result_valid_d  = result_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.op_valid_i) begin
                    quot_neg_d = bus.signed_i & (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
                    rem_neg_d  = bus.signed_i & op_a[DATA_WIDTH-1];
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    if (bus.divisor_i == '0) begin
                        quotient_d     = ALL_ONES;
                        remainder_d    = bus.dividend_i;
                        dbz_d          = 1'b1;
                        result_valid_d = 1'b1;
                        state_d        = RESULT;
                    end else if (bus.signed_i && bus.dividend_i == MIN_VAL &&
                                 bus.divisor_i == ALL_ONES) begin
                        quotient_d     = MIN_VAL;
                        remainder_d    = '0;
                        ovf_d          = 1'b1;
                        result_valid_d = 1'b1;
                        state_d        = RESULT;
                    end else if (mag_a < mag_b) begin
                        // The core cannot handle a dividend smaller than the divisor.
                        quotient_d     = '0;
                        remainder_d    = bus.dividend_i;
                        result_valid_d = 1'b1;
                        state_d        = RESULT;
                    end else begin
                        core_dividend_d = mag_a;
                        core_divisor_d  = mag_b;
                        state_d         = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.core_idle_i) begin
                    core_valid_d = 1'b1;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (bus.core_valid_i) begin
                    core_quot_d = bus.core_quotient_i;
                    core_rem_d  = bus.core_remainder_i;
                    state_d     = FIXUP;
                end
            end
            FIXUP: begin
                quotient_d     = quot_neg_q ? negate(core_quot_q) : core_quot_q;
                remainder_d    = rem_neg_q ? negate(core_rem_q) : core_rem_q;
                result_valid_d = 1'b1;
                state_d        = RESULT;
            end
            RESULT: begin
                if (bus.result_ready_i) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= IDLE;
            quot_neg_q      <= 1'b0;
            rem_neg_q       <= 1'b0;
            core_dividend_q <= '0;
            core_divisor_q  <= '0;
            core_valid_q    <= 1'b0;
            core_quot_q     <= '0;
            core_rem_q      <= '0;
            quotient_q      <= '0;
            remainder_q     <= '0;
            dbz_q           <= 1'b0;
            ovf_q           <= 1'b0;
            result_valid_q  <= 1'b0;
        end else if (clk_en_i) begin
            state_q         <= state_d;
            quot_neg_q      <= quot_neg_d;
            rem_neg_q       <= rem_neg_d;
            core_dividend_q <= core_dividend_d;
            core_divisor_q  <= core_divisor_d;
            core_valid_q    <= core_valid_d;
            core_quot_q     <= core_quot_d;
            core_rem_q      <= core_rem_d;
            quotient_q      <= quotient_d;
            remainder_q     <= remainder_d;
            dbz_q           <= dbz_d;
            ovf_q           <= ovf_d;
            result_valid_q  <= result_valid_d;
        end
    end

    assign bus.op_ready_o       = (state_q == IDLE);
    assign bus.core_dividend_o  = core_dividend_q;
    assign bus.core_divisor_o   = core_divisor_q;
    assign bus.core_valid_o     = core_valid_q;
    assign bus.result_valid_o   = result_valid_q;
    assign bus.quotient_o       = quotient_q;
    assign bus.remainder_o      = remainder_q;
    assign bus.divide_by_zero_o = dbz_q;
    assign bus.overflow_o       = ovf_q;
endmodule

// File: tb/tb_signed_divider_adapter.sv
// Bench for signed_divider_adapter with a behavioural unsigned divider core
// on the core side and a plain-arithmetic reference for the signed results.
module tb_signed_divider_adapter;
    localparam int N = 16;
    localparam logic [N-1:0] MINV = 16'h8000;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         s;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic         ovf;
        logic         core;
        logic [N-1:0] ca;
        logic [N-1:0] cb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clk_en = 1'b1;
    logic force_busy;
    logic stale_pulse;

    int total = 0;
    int bad = 0;
    int lat;
    int pulses0;
    int core_lat;

    signed_divider_adapter_if #(.DATA_WIDTH(N)) dif ();

    signed_divider_adapter #(.DATA_WIDTH(N)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .clk_en_i (clk_en),
        .bus      (dif.slave)
    );

    always #5 clk = ~clk;

    // Behavioural unsigned core: L enabled cycles after a start pulse it
    // returns a/b and a%b as a one-cycle pulse; busy while computing.
    logic         core_pend;
    logic         core_vld_m;
    int           core_cnt;
    int           core_pulses;
    logic [N-1:0] seen_a, seen_b, core_q_m, core_r_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_pend   <= 1'b0;
            core_vld_m  <= 1'b0;
            core_cnt    <= 0;
            core_pulses <= 0;
        end else if (clk_en) begin
            core_vld_m <= 1'b0;
            if (dif.core_valid_o) begin
                core_pend   <= 1'b1;
                core_cnt    <= core_lat;
                seen_a      <= dif.core_dividend_o;
                seen_b      <= dif.core_divisor_o;
                core_pulses <= core_pulses + 1;
            end else if (core_pend) begin
                if (core_cnt <= 1) begin
                    core_pend  <= 1'b0;
                    core_vld_m <= 1'b1;
                    core_q_m   <= (seen_b == '0) ? '1 : seen_a / seen_b;
                    core_r_m   <= (seen_b == '0) ? seen_a : seen_a % seen_b;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    assign dif.core_idle_i      = ~core_pend & ~force_busy;
    assign dif.core_valid_i     = core_vld_m | stale_pulse;
    assign dif.core_quotient_i  = core_q_m;
    assign dif.core_remainder_i = core_r_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer division truncating toward zero,
    // remainder follows the dividend, plus the divide-by-zero/overflow rules.
    function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        vec_t   v;
        longint ai, bi, qi, ri, ma, mb;
        v.a = a; v.b = b; v.s = s;
        v.dbz = 1'b0; v.ovf = 1'b0; v.core = 1'b0; v.ca = '0; v.cb = '0;
        v.q = '0; v.r = '0;
        if (s) begin
            ai = longint'($signed(a));
            bi = longint'($signed(b));
        end else begin
            ai = longint'(a);
            bi = longint'(b);
        end
        if (b == '0) begin
            v.q = '1; v.r = a; v.dbz = 1'b1;
        end else if (s && a == MINV && b == '1) begin
            v.q = MINV; v.r = '0; v.ovf = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            v.q = qi[N-1:0];
            v.r = ri[N-1:0];
            ma = (ai < 0) ? -ai : ai;
            mb = (bi < 0) ? -bi : bi;
            v.core = (ma >= mb);
            v.ca = ma[N-1:0];
            v.cb = mb[N-1:0];
        end
        return v;
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        int n = 0;
        dif.dividend_i = a;
        dif.divisor_i  = b;
        dif.signed_i   = s;
        dif.op_valid_i = 1'b1;
        pulses0 = core_pulses;
        while (dif.op_ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(dif.op_ready_o), 32'd1);
        @(negedge clk);
        dif.op_valid_i = 1'b0;
        lat = 1;
    endtask

    task automatic finish_op(input vec_t e, input int hold, input bit chk_lat);
        int n = 0;
        while (dif.result_valid_o !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            lat++;
        end
        chk("result_seen", 32'(dif.result_valid_o), 32'd1);
        if (dif.result_valid_o !== 1'b1) return;
        if (chk_lat) chk("latency", lat, e.core ? core_lat + 5 : 1);
        chk("quotient", 32'(dif.quotient_o), 32'(e.q));
        chk("remainder", 32'(dif.remainder_o), 32'(e.r));
        chk("dbz", 32'(dif.divide_by_zero_o), 32'(e.dbz));
        chk("ovf", 32'(dif.overflow_o), 32'(e.ovf));
        chk("core_pulses", core_pulses - pulses0, e.core ? 1 : 0);
        if (e.core) begin
            chk("core_dividend", 32'(seen_a), 32'(e.ca));
            chk("core_divisor", 32'(seen_b), 32'(e.cb));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(dif.result_valid_o), 32'd1);
            chk("hold_ready", 32'(dif.op_ready_o), 32'd0);
            chk("hold_quotient", 32'(dif.quotient_o), 32'(e.q));
            chk("hold_remainder", 32'(dif.remainder_o), 32'(e.r));
        end
        dif.result_ready_i = 1'b1;
        @(negedge clk);
        dif.result_ready_i = 1'b0;
        chk("valid_drop", 32'(dif.result_valid_o), 32'd0);
        chk("ready_back", 32'(dif.op_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [16];
        vec_t e;
        logic [N-1:0] a, b;
        logic s;
        int n;

        dif.op_valid_i = 1'b0; dif.dividend_i = '0; dif.divisor_i = '0;
        dif.signed_i = 1'b0; dif.result_ready_i = 1'b0;
        force_busy = 1'b0; stale_pulse = 1'b0; core_lat = 2;

        //          a         b         s     q         r         dbz   ovf   core  ca        cb
        tbl[0]  = '{16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0064, 16'h0007};
        tbl[1]  = '{16'h0064, 16'h0007, 1'b1, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0064, 16'h0007};
        tbl[2]  = '{16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 1'b1, 16'h0064, 16'h0007};
        tbl[3]  = '{16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0064, 16'h0007};
        tbl[4]  = '{16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 1'b1, 16'h0064, 16'h0007};
        tbl[5]  = '{16'h04D2, 16'h0000, 1'b0, 16'hFFFF, 16'h04D2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[6]  = '{16'h04D2, 16'h0000, 1'b1, 16'hFFFF, 16'h04D2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[7]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[8]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[9]  = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h0001};
        tbl[10] = '{16'h0005, 16'h0009, 1'b1, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[11] = '{16'hFFFB, 16'h0009, 1'b1, 16'h0000, 16'hFFFB, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[12] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[13] = '{16'h0007, 16'h0007, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0007, 16'h0007};
        tbl[14] = '{16'hFFFF, 16'h0002, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0002};
        tbl[15] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h8000};

        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_op_ready", 32'(dif.op_ready_o), 32'd1);
        chk("rst_core_valid", 32'(dif.core_valid_o), 32'd0);
        chk("rst_result_valid", 32'(dif.result_valid_o), 32'd0);
        chk("rst_quotient", 32'(dif.quotient_o), 32'd0);
        chk("rst_remainder", 32'(dif.remainder_o), 32'd0);
        chk("rst_flags", 32'({dif.divide_by_zero_o, dif.overflow_o}), 32'd0);
        chk("rst_core_ops", 32'({dif.core_dividend_o, dif.core_divisor_o}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            start_op(tbl[i].a, tbl[i].b, tbl[i].s);
            finish_op(tbl[i], 0, 1);
        end

        // Backpressure: result held for 5 cycles with the consumer not ready.
        start_op(16'd100, 16'd7, 1'b0);
        finish_op(tbl[0], 5, 1);

        // Busy core: start pulse must wait until the core reports idle.
        force_busy = 1'b1;
        e = model(16'd1000, 16'd9, 1'b0);
        start_op(16'd1000, 16'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("busy_no_start", 32'(dif.core_valid_o), 32'd0);
            chk("busy_ready", 32'(dif.op_ready_o), 32'd0);
            chk("busy_core_a", 32'(dif.core_dividend_o), 32'd1000);
            chk("busy_core_b", 32'(dif.core_divisor_o), 32'd9);
            @(negedge clk);
        end
        force_busy = 1'b0;
        finish_op(e, 0, 0);

        // Clock enable low while the core result pulse is pending in WAIT.
        core_lat = 3;
        e = model(16'hFC18, 16'd9, 1'b1);
        start_op(16'hFC18, 16'd9, 1'b1);
        n = 0;
        while (dif.core_valid_i !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("freeze_core_done", 32'(dif.core_valid_i), 32'd1);
        clk_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("freeze_valid", 32'(dif.result_valid_o), 32'd0);
            chk("freeze_ready", 32'(dif.op_ready_o), 32'd0);
            chk("freeze_core_a", 32'(dif.core_dividend_o), 32'd1000);
        end
        clk_en = 1'b1;
        finish_op(e, 0, 0);

        // Asynchronous reset in the middle of WAIT, then a stale core pulse.
        core_lat = 6;
        start_op(16'd500, 16'd3, 1'b0);
        n = 0;
        while (core_pulses == pulses0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reset_in_wait", 32'(dif.op_ready_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_op_ready", 32'(dif.op_ready_o), 32'd1);
        chk("arst_result_valid", 32'(dif.result_valid_o), 32'd0);
        chk("arst_core_valid", 32'(dif.core_valid_o), 32'd0);
        chk("arst_core_a", 32'(dif.core_dividend_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stale_pulse = 1'b1;
        @(negedge clk);
        stale_pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_valid", 32'(dif.result_valid_o), 32'd0);
            chk("stale_ready", 32'(dif.op_ready_o), 32'd1);
            chk("stale_quotient", 32'(dif.quotient_o), 32'd0);
        end
        core_lat = 2;
        start_op(tbl[4].a, tbl[4].b, tbl[4].s);
        finish_op(tbl[4], 0, 1);

        // Randomised operands against the reference model.
        for (int k = 0; k < 150; k++) begin
            a = N'($urandom);
            b = N'($urandom);
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MINV; b = '1; end
                2: b = N'($urandom_range(1, 40));
                3: begin a = N'($urandom_range(0, 3000)); b = N'($urandom_range(1, 60)); end
                4: begin a = MINV; b = N'($urandom_range(1, 5)); end
                default: ;
            endcase
            core_lat = $urandom_range(1, 4);
            e = model(a, b, s);
            start_op(a, b, s);
            finish_op(e, $urandom_range(0, 2), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
